// File: rtl/proj_switch_pkg.sv
// Shared types and default sizing for the project switch.
package proj_switch_pkg;

   localparam int DEF_NUM_DESIGNS = 8;
   localparam int DEF_SEL_BITS    = 3;
   localparam int DEF_INPUT_BITS  = 16;
   localparam int DEF_OUTPUT_BITS = 16;

   // GATE: everything parked; RST: new owner clocked in reset; RUN: owner live
   typedef enum logic [1:0] {
      ST_GATE = 2'd0,
      ST_RST  = 2'd1,
      ST_RUN  = 2'd2
   } state_e;

endpackage

// File: rtl/proj_clk_gate.sv
// Glitch-free clock gate for one project: the enable is captured while clk
// is low, so the AND can only start or stop on a full high phase.
module proj_clk_gate (
   input  logic clk,
   input  logic rst_n,
   input  logic en_d,
   output logic gclk
);

   logic en_q;

   // enable register clocked on the falling edge
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) en_q <= 1'b0;
      else        en_q <= en_d;
   end

   assign gclk = clk & en_q;

endmodule

// File: rtl/proj_switch.sv
// Project switch: time-multiplexes one shared I/O bus over NUM_DESIGNS
// attached projects. A new selection must be stable for STABLE_CYCLES before
// the switch gates all clocks for one cycle, then clocks the new owner through
// a RST_CYCLES reset pulse and releases it into RUN.
// Optional build macro PROJ_SWITCH_SEL_SYNC_EN: sel passes through a 2-flop
// synchroniser (adds 2 cycles of switch latency).
module proj_switch
   import proj_switch_pkg::*;
#(
   parameter int NUM_DESIGNS   = DEF_NUM_DESIGNS,
   parameter int SEL_BITS      = DEF_SEL_BITS,
   parameter int INPUT_BITS    = DEF_INPUT_BITS,
   parameter int OUTPUT_BITS   = DEF_OUTPUT_BITS,
   parameter int RST_CYCLES    = 4,
   parameter int STABLE_CYCLES = 2
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [SEL_BITS-1:0]                sel,
   input  logic [INPUT_BITS-1:0]              in,
   output logic [OUTPUT_BITS-1:0]             out,
   output logic [NUM_DESIGNS-1:0]             proj_clk,
   output logic [NUM_DESIGNS-1:0]             proj_rst_n,
   output logic [NUM_DESIGNS*INPUT_BITS-1:0]  proj_in,
   input  logic [NUM_DESIGNS*OUTPUT_BITS-1:0] proj_out,
   output logic [SEL_BITS-1:0]                active_sel,
   output logic                               busy
);

   localparam int CNT_W  = $clog2(STABLE_CYCLES + 1);
   localparam int RCNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [CNT_W-1:0]  STABLE_MAX = CNT_W'(STABLE_CYCLES);
   localparam logic [RCNT_W-1:0] RCNT_LOAD  = RCNT_W'(RST_CYCLES - 1);
   localparam logic [SEL_BITS:0] NUM_LIM    = (SEL_BITS + 1)'(NUM_DESIGNS);

   logic [SEL_BITS-1:0]    sel_s;
   logic [SEL_BITS-1:0]    cand_q, cand_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   state_e                 state_q, state_d;
   logic [SEL_BITS-1:0]    active_q, active_d;
   logic [RCNT_W-1:0]      rcnt_q, rcnt_d;
   logic [OUTPUT_BITS-1:0] out_q, out_d;
   logic [OUTPUT_BITS-1:0] owner_out;
   logic [NUM_DESIGNS-1:0] en_d;
   logic                   switch_req;

`ifdef PROJ_SWITCH_SEL_SYNC_EN
   logic [SEL_BITS-1:0] sync1_q, sync1_d, sync2_q, sync2_d;

   // synchroniser next values: plain shift
   always_comb begin
      sync1_d = sel;
      sync2_d = sync1_q;
   end

   // two-stage synchroniser for an asynchronous sel source
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

   assign sel_s = sync2_q;
`else
   assign sel_s = sel;
`endif

   // candidate tracking: restart the age on any change, saturate when stable
   always_comb begin
      cand_d = cand_q;
      cnt_d  = cnt_q;
      if (sel_s != cand_q) begin
         cand_d = sel_s;
         cnt_d  = '0;
      end else if (cnt_q != STABLE_MAX) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // out-of-range candidates never request a switch; the owner keeps running
   assign switch_req = (cnt_q == STABLE_MAX) && (cand_q != active_q) &&
                       ({1'b0, cand_q} < NUM_LIM);

   // FSM next state; an RST in progress always runs to completion
   always_comb begin
      state_d  = state_q;
      active_d = active_q;
      rcnt_d   = rcnt_q;
      unique case (state_q)
         ST_RUN: begin
            if (switch_req) state_d = ST_GATE;
         end
         ST_GATE: begin
            state_d  = ST_RST;
            active_d = cand_q;
            rcnt_d   = RCNT_LOAD;
         end
         ST_RST: begin
            if (rcnt_q == '0) state_d = ST_RUN;
            else              rcnt_d  = rcnt_q - 1'b1;
         end
         default: begin
            state_d  = ST_RST;
            active_d = '0;
            rcnt_d   = RCNT_LOAD;
         end
      endcase
   end

   // clock enables look at the next state: the negedge flop then applies
   // them to exactly the cycle they belong to, keeping GATE fully quiet
   always_comb begin
      en_d       = '0;
      proj_rst_n = '0;
      for (int i = 0; i < NUM_DESIGNS; i++) begin
         if (state_d != ST_GATE && active_d == SEL_BITS'(i)) en_d[i] = 1'b1;
         if (state_q == ST_RUN && active_q == SEL_BITS'(i)) proj_rst_n[i] = 1'b1;
      end
   end

   // route the shared input to the owner only; other slices are held at 0
   always_comb begin
      proj_in = '0;
      for (int i = 0; i < NUM_DESIGNS; i++) begin
         if (active_q == SEL_BITS'(i)) proj_in[i*INPUT_BITS +: INPUT_BITS] = in;
      end
   end

   // pick the owner's output slice; registered only when the next cycle is RUN
   always_comb begin
      owner_out = '0;
      for (int i = 0; i < NUM_DESIGNS; i++) begin
         if (active_q == SEL_BITS'(i)) owner_out = proj_out[i*OUTPUT_BITS +: OUTPUT_BITS];
      end
      out_d = (state_d == ST_RUN) ? owner_out : '0;
   end

   // all posedge state; reset restarts project 0 with a full reset pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_RST;
         active_q <= '0;
         rcnt_q   <= RCNT_LOAD;
         cand_q   <= '0;
         cnt_q    <= '0;
         out_q    <= '0;
      end else begin
         state_q  <= state_d;
         active_q <= active_d;
         rcnt_q   <= rcnt_d;
         cand_q   <= cand_d;
         cnt_q    <= cnt_d;
         out_q    <= out_d;
      end
   end

   for (genvar g = 0; g < NUM_DESIGNS; g++) begin : g_gate
      proj_clk_gate u_gate (
         .clk   (clk),
         .rst_n (rst_n),
         .en_d  (en_d[g]),
         .gclk  (proj_clk[g])
      );
   end

   assign out        = out_q;
   assign active_sel = active_q;
   assign busy       = (state_q != ST_RUN);

endmodule

// File: tb/tb_proj_switch.sv
// Bench for proj_switch: spec-level cycle model plus directed scenarios.
module tb_proj_switch;

   localparam int ND = 6;
   localparam int SB = 3;
   localparam int IB = 16;
   localparam int OB = 16;
   localparam int RC = 4;
   localparam int SC = 2;
`ifdef PROJ_SWITCH_SEL_SYNC_EN
   localparam int SL = 2;
`else
   localparam int SL = 0;
`endif

   localparam int M_GATE = 0;
   localparam int M_RST  = 1;
   localparam int M_RUN  = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [SB-1:0]     sel;
   logic [IB-1:0]     in_bus;
   logic [OB-1:0]     out;
   logic [ND-1:0]     proj_clk;
   logic [ND-1:0]     proj_rst_n;
   logic [ND*IB-1:0]  proj_in;
   logic [ND*OB-1:0]  proj_out;
   logic [SB-1:0]     active_sel;
   logic              busy;

   int vecs = 0;
   int errs = 0;
   int cyc  = 0;

   always #5 clk = ~clk;

   proj_switch #(
      .NUM_DESIGNS(ND), .SEL_BITS(SB), .INPUT_BITS(IB), .OUTPUT_BITS(OB),
      .RST_CYCLES(RC), .STABLE_CYCLES(SC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .sel(sel), .in(in_bus), .out(out),
      .proj_clk(proj_clk), .proj_rst_n(proj_rst_n), .proj_in(proj_in),
      .proj_out(proj_out), .active_sel(active_sel), .busy(busy)
   );

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int         m_state, m_active, m_cand, m_age, m_rst_left, sh1, sh2;
   logic [OB-1:0] m_out;
   bit         m_clk_ok;

   // a project clock can only be live after a falling edge seen out of reset
   always @(negedge clk or negedge rst_n) m_clk_ok <= rst_n;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_state <= M_RST; m_active <= 0; m_cand <= 0; m_age <= 0;
         m_rst_left <= RC; m_out <= '0; sh1 <= 0; sh2 <= 0;
      end else begin
         int seen, nst, nact, nleft;
         seen = (SL == 2) ? sh2 : int'(sel);
         sh1 <= int'(sel);
         sh2 <= sh1;
         if (seen != m_cand) begin m_cand <= seen; m_age <= 0; end
         else m_age <= m_age + 1;
         nst = m_state; nact = m_active; nleft = m_rst_left;
         if (m_state == M_RUN) begin
            if (m_age >= SC && m_cand != m_active && m_cand < ND) nst = M_GATE;
         end else if (m_state == M_GATE) begin
            nst = M_RST; nact = m_cand; nleft = RC;
         end else begin
            nleft = m_rst_left - 1;
            if (nleft == 0) nst = M_RUN;
         end
         m_out      <= (nst == M_RUN) ? proj_out[m_active*OB +: OB] : '0;
         m_state    <= nst;
         m_active   <= nact;
         m_rst_left <= nleft;
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      logic [ND-1:0]    e_rst, e_clk;
      logic [ND*IB-1:0] e_in;
      forever begin
         @(posedge clk); #3;
         for (int i = 0; i < ND; i++) begin
            e_rst[i] = (m_state == M_RUN) && (m_active == i);
            e_clk[i] = m_clk_ok && (m_state != M_GATE) && (m_active == i);
            e_in[i*IB +: IB] = (m_active == i) ? in_bus : '0;
         end
         chk("out", out, m_out);
         chk("active_sel", active_sel, m_active);
         chk("busy", busy, m_state != M_RUN);
         chk("proj_rst_n", proj_rst_n, e_rst);
         chk("proj_clk_high", proj_clk, e_clk);
         chk("proj_in", proj_in, e_in);
         #4;
         chk("proj_clk_low", proj_clk, '0);
      end
   end

   // project outputs: distinct, changing pattern per slice
   initial begin
      proj_out = '0;
      forever begin
         @(posedge clk); #1;
         cyc++;
         for (int i = 0; i < ND; i++)
            proj_out[i*OB +: OB] = OB'(i * 32'h1000 + ((cyc * 32'h0137) & 32'h0fff));
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         in_bus = in_bus + 16'h0123;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   // ---------------- directed scenarios ----------------
   initial begin
      logic [OB-1:0] v;
      rst_n = 1'b1; sel = '0; in_bus = 16'h1234;
      #1 rst_n = 1'b0;
      tick(3); #2;
      chk("rst_busy", busy, 1'b1);
      chk("rst_out", out, 16'h0);
      chk("rst_prst", proj_rst_n, 6'b000000);
      chk("rst_active", active_sel, 3'd0);

      // release: project 0 held in reset 4 cycles, then RUN
      tick(1); rst_n = 1'b1;
      tick(3); #2;
      chk("rel_busy_rst", busy, 1'b1);
      chk("rel_prst_low", proj_rst_n, 6'b000000);
      tick(1); #2;
      chk("rel_busy_run", busy, 1'b0);
      chk("rel_prst_high", proj_rst_n, 6'b000001);
      chk("rel_clk0", proj_clk, 6'b000001);
      v = proj_out[15:0];
      tick(1); #2;
      chk("rel_out_track", out, v);

      // one-cycle glitch on sel: no switch
      tick(1); sel = 3'd5;
      tick(1); sel = 3'd0;
      tick(6); #2;
      chk("glitch_busy", busy, 1'b0);
      chk("glitch_active", active_sel, 3'd0);

      // switch 0 -> 5
      tick(1); sel = 3'd5;
      tick(3 + SL); #2;
      chk("sw5_pre_busy", busy, 1'b0);
      tick(1); #2;
      chk("sw5_gate_busy", busy, 1'b1);
      chk("sw5_gate_clk", proj_clk, 6'b000000);
      chk("sw5_gate_prst", proj_rst_n, 6'b000000);
      chk("sw5_gate_out", out, 16'h0);
      tick(1); #2;
      chk("sw5_active", active_sel, 3'd5);
      chk("sw5_rst_clk", proj_clk, 6'b100000);
      chk("sw5_rst_prst", proj_rst_n, 6'b000000);
      tick(3); #2;
      chk("sw5_rst_end", busy, 1'b1);
      tick(1); #2;
      chk("sw5_run", busy, 1'b0);
      chk("sw5_run_prst", proj_rst_n, 6'b100000);

      // out-of-range selections are ignored
      tick(1); sel = 3'd7;
      tick(8); #2;
      chk("oor7_active", active_sel, 3'd5);
      chk("oor7_busy", busy, 1'b0);
      tick(1); sel = 3'd6;
      tick(8); #2;
      chk("oor6_active", active_sel, 3'd5);

      // back to 0, then 5, with sel moving to 2 during project 5's reset
      tick(1); sel = 3'd0;
      tick(12 + SL); #2;
      chk("back0_active", active_sel, 3'd0);
      tick(1); sel = 3'd5;
      tick(4 + SL);
      tick(1); sel = 3'd2;
      tick(3); #2;
      chk("mid_rst_busy", busy, 1'b1);
      chk("mid_rst_active", active_sel, 3'd5);
      tick(1); #2;
      chk("mid_run_busy", busy, 1'b0);
      tick(1 + SL); #2;
      chk("pend_gate_busy", busy, 1'b1);
      tick(1); #2;
      chk("pend_active", active_sel, 3'd2);

      // reset asserted in the middle of a switch
      tick(6);
      tick(1); sel = 3'd4;
      tick(4 + SL); rst_n = 1'b0; #2;
      chk("midsw_busy", busy, 1'b1);
      chk("midsw_active", active_sel, 3'd0);
      chk("midsw_out", out, 16'h0);
      chk("midsw_prst", proj_rst_n, 6'b000000);
      chk("midsw_clk", proj_clk, 6'b000000);
      sel = 3'd0;
      tick(2); rst_n = 1'b1;
      tick(3); #2;
      chk("rerst_busy", busy, 1'b1);
      tick(1); #2;
      chk("rerst_run", busy, 1'b0);
      chk("rerst_prst", proj_rst_n, 6'b000001);

      tick(5);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/proj_switch.md
PROJ_SWITCH -- requirements
Module: proj_switch

Interface
REQ-001 SHALL have parameter NUM_DESIGNS, default 8: number of attached projects.
REQ-002 SHALL have parameter SEL_BITS, default 3: selector width, with 2**SEL_BITS >= NUM_DESIGNS.
REQ-003 SHALL have parameter INPUT_BITS, default 16: per-project input width.
REQ-004 SHALL have parameter OUTPUT_BITS, default 16: per-project output width.
REQ-005 SHALL have parameter RST_CYCLES, default 4 (>=1): length of the reset pulse given to a newly selected project.
REQ-006 SHALL have parameter STABLE_CYCLES, default 2 (>=1): how long sel must hold a value before a switch.
REQ-007 SHALL have the following ports:
- clk  in  1  the single clock; all logic is in this domain.
- rst_n  in  1  asynchronous, active-low reset.
- sel  in  SEL_BITS  requested project index.
- in  in  INPUT_BITS  shared input bus.
- out  out  OUTPUT_BITS  output of the active project.
- proj_clk  out  NUM_DESIGNS  gated clock, one per project.
- proj_rst_n  out  NUM_DESIGNS  active-low reset, one per project.
- proj_in  out  NUM_DESIGNS*INPUT_BITS  input slices; slice i is [i*INPUT_BITS +: INPUT_BITS].
- proj_out  in  NUM_DESIGNS*OUTPUT_BITS  project output slices.
- active_sel  out  SEL_BITS  index of the currently owned project.
- busy  out  1  high in any state other than RUN.

Function
REQ-008 SHALL implement the FSM states GATE, RST and RUN.
REQ-009 SHALL track sel in a candidate register plus a stability counter:
- the counter clears whenever sel differs from the candidate;
- the counter saturates at STABLE_CYCLES.
REQ-010 SHALL go RUN->GATE when the counter equals STABLE_CYCLES, candidate != active_sel and candidate < NUM_DESIGNS.
REQ-011 SHALL ignore out-of-range sel values (>= NUM_DESIGNS); the active project keeps running.
REQ-012 SHALL keep GATE for exactly 1 cycle:
- all clock enables 0, all proj_rst_n 0;
- on exit, active_sel <= candidate and the FSM goes to RST.
REQ-013 SHALL keep RST for exactly RST_CYCLES cycles:
- enable[active_sel]=1 and proj_rst_n[active_sel]=0;
- then go to RUN.
REQ-014 SHALL, in RUN, hold enable[active_sel]=1 and proj_rst_n[active_sel]=1.
REQ-015 SHALL keep every non-active project at enable 0 and proj_rst_n 0 in all states.
REQ-016 SHALL drive proj_clk[i] = clk AND enable_q[i], where enable_q is registered on the falling edge of clk, so the gated clock is glitch-free.
REQ-017 SHALL drive the proj_in active slice combinationally from in; every other slice is 0.
REQ-018 SHALL register out from the proj_out slice of active_sel, with 1-cycle latency, in RUN only; out is 0 in GATE and RST.
REQ-019 SHALL not abort an RST already in progress when sel changes; candidate tracking continues, and a pending switch is taken on the first RUN cycle.

Reset
REQ-020 SHALL, while rst_n is low:
- set state=RST, active_sel=0, RST counter loaded, candidate=0 with counter cleared;
- set out=0, busy=1, all enables 0, all proj_rst_n 0.
REQ-021 SHALL, after rst_n deasserts, give project 0 a full RST_CYCLES reset pulse and then enter RUN.
REQ-022 SHALL, if rst_n asserts mid-switch, abandon the switch and follow REQ-020.

Configuration
REQ-023 SHALL, with macro PROJ_SWITCH_SEL_SYNC_EN defined, pass sel through a 2-flop synchroniser before candidate tracking, adding 2 cycles to switch latency; both flops reset to 0.
REQ-024 SHALL, without PROJ_SWITCH_SEL_SYNC_EN, sample sel directly.

Structure
REQ-025 SHALL place the FSM state enum and the defaults for NUM_DESIGNS/SEL_BITS/INPUT_BITS/OUTPUT_BITS in shared package proj_switch_pkg.
REQ-026 SHALL implement the per-project glitch-free gate (negedge enable flop plus AND) as sub-module proj_clk_gate, instantiated NUM_DESIGNS times.

Verification
REQ-027 SHALL cover: release reset with sel=0 -> proj_rst_n[0] low for 4 cycles then high, busy falls, out tracks proj_out[15:0] one cycle later.
REQ-028 SHALL cover: sel 0->5, held -> after 2 stable cycles GATE for 1 cycle (all clocks quiet), proj_rst_n[5] low 4 cycles, active_sel=5, no proj_clk pulse shorter than half a period.
REQ-029 SHALL cover: sel=5 for 1 cycle, then back to 0 -> no switch, busy stays 0.
REQ-030 SHALL cover: sel=7 with NUM_DESIGNS=6 -> ignored, active_sel unchanged.
REQ-031 SHALL cover: sel changes to 2 during RST of project 5 -> RST completes, then a 2->GATE switch starts on the first RUN cycle.
REQ-032 SHALL cover: rst_n pulsed low during GATE -> all outputs at reset values, project 0 re-reset; with PROJ_SWITCH_SEL_SYNC_EN, switch latency +2 cycles.
